// File: rtl/axi4s_dwidth_down_conv_pkg.sv
// Shared definitions for the AXI4-Stream width down-converter: default widths,
// ratio helper, beat-index type and the holding-register state encoding.
package axi4s_dwc_pkg;

    localparam int unsigned DWC_IN_W_DFLT  = 32;
    localparam int unsigned DWC_OUT_W_DFLT = 8;

    function automatic int unsigned dwc_ratio(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    localparam int unsigned DWC_RATIO_DFLT = dwc_ratio(DWC_IN_W_DFLT, DWC_OUT_W_DFLT);

    typedef logic [$clog2(DWC_RATIO_DFLT)-1:0] dwc_idx_t;

    typedef enum logic {
        DWC_EMPTY = 1'b0,
        DWC_FULL  = 1'b1
    } dwc_state_e;

endpackage

// File: rtl/axi4s_dwidth_down_conv_if.sv
// Minimal AXI4-Stream link (TDATA/TVALID/TREADY only) used on both sides of the converter.
interface axi4s_dwidth_down_conv_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axi4s_dwidth_down_conv.sv
// AXI4-Stream width down-converter: holds one wide word and emits it as RATIO
// narrow beats, back-to-back with the next word when both sides keep up.
module axi4s_dwidth_down_conv
    import axi4s_dwc_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = DWC_IN_W_DFLT,
    parameter int unsigned OUT_WIDTH = DWC_OUT_W_DFLT,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axi4s_dwidth_down_conv_if.slave  s_axis,
    axi4s_dwidth_down_conv_if.master m_axis,
    output logic                     busy
);

    localparam int unsigned RATIO = dwc_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t IDX_LAST = idx_t'(RATIO - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_cfg
        $error("axi4s_dwidth_down_conv: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
    end

    dwc_state_e          state_q, state_d;
    logic [IN_WIDTH-1:0] hold_q, hold_d;
    idx_t                idx_q, idx_d;
    logic                rst_done_q, rst_done_d;

    logic full;
    logic last_beat;
    logic s_ready;
    logic s_hs;
    logic m_hs;
    idx_t slice_sel;

    always_comb begin
        full      = (state_q == DWC_FULL);
        last_beat = (idx_q == IDX_LAST);
        m_hs      = full & m_axis.tready;
        // The word slot frees up in the same cycle its last beat is taken.
        s_ready   = rst_done_q & (~full | (m_axis.tready & last_beat));
        s_hs      = s_ready & s_axis.tvalid;

        state_d    = state_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        rst_done_d = 1'b1;

        if (s_hs) begin
            hold_d  = s_axis.tdata;
            idx_d   = '0;
            state_d = DWC_FULL;
        end else if (m_hs) begin
            if (last_beat) begin
                idx_d   = '0;
                state_d = DWC_EMPTY;
            end else begin
                idx_d = idx_t'(idx_q + 1'b1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= DWC_EMPTY;
            hold_q     <= '0;
            idx_q      <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            rst_done_q <= rst_done_d;
        end
    end

    always_comb begin
        slice_sel = LSB_FIRST ? idx_q : idx_t'(IDX_LAST - idx_q);
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = full;
    assign m_axis.tdata  = hold_q[32'(slice_sel) * OUT_WIDTH +: OUT_WIDTH];
    assign busy          = full;

endmodule

// File: tb/tb_axi4s_dwidth_down_conv.sv
// Directed scoreboard bench: stimulus pushes expected beats, negedge monitors pop and compare.
module tb_axi4s_dwidth_down_conv;

    logic aclk;
    logic aresetn;
    logic busy_a;
    logic busy_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;
    bit          gap_en   = 1'b0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    axi4s_dwidth_down_conv_if #(.DATA_W(32)) s_if ();
    axi4s_dwidth_down_conv_if #(.DATA_W(8))  m_if ();
    axi4s_dwidth_down_conv_if #(.DATA_W(32)) s2_if ();
    axi4s_dwidth_down_conv_if #(.DATA_W(8))  m2_if ();

    axi4s_dwidth_down_conv #(
        .IN_WIDTH (32),
        .OUT_WIDTH(8),
        .LSB_FIRST(1'b1)
    ) dut_lsb (
        .aclk   (aclk),
        .aresetn(aresetn),
        .s_axis (s_if),
        .m_axis (m_if),
        .busy   (busy_a)
    );

    axi4s_dwidth_down_conv #(
        .IN_WIDTH (32),
        .OUT_WIDTH(8),
        .LSB_FIRST(1'b0)
    ) dut_msb (
        .aclk   (aclk),
        .aresetn(aresetn),
        .s_axis (s2_if),
        .m_axis (m2_if),
        .busy   (busy_b)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge aclk) begin
        if (aresetn && m_if.tvalid && m_if.tready) begin
            if (exp_a.size() == 0) chk("lsb_unexpected_beat", {24'h0, m_if.tdata}, 32'hFFFF_FFFF);
            else chk("lsb_beat", {24'h0, m_if.tdata}, {24'h0, exp_a.pop_front()});
        end
        if (aresetn && gap_en) chk("no_bubble", {31'h0, m_if.tvalid}, 32'h1);
    end

    always @(negedge aclk) begin
        if (aresetn && m2_if.tvalid && m2_if.tready) begin
            if (exp_b.size() == 0) chk("msb_unexpected_beat", {24'h0, m2_if.tdata}, 32'hFFFF_FFFF);
            else chk("msb_beat", {24'h0, m2_if.tdata}, {24'h0, exp_b.pop_front()});
        end
    end

    task automatic send_a(input logic [31:0] w, output int acc);
        s_if.tdata  = w;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 4; i++) exp_a.push_back(w[8*i +: 8]);
        for (int t = 0; t < 50; t++) begin
            @(negedge aclk);
            if (s_if.tready) begin
                @(posedge aclk);
                #1;
                acc = cyc;
                return;
            end
            @(posedge aclk);
            #1;
        end
        chk("lsb_accept_timeout", 32'h0, 32'h1);
        s_if.tvalid = 1'b0;
        acc = -1;
    endtask

    task automatic send_b(input logic [31:0] w);
        s2_if.tdata  = w;
        s2_if.tvalid = 1'b1;
        for (int i = 3; i >= 0; i--) exp_b.push_back(w[8*i +: 8]);
        for (int t = 0; t < 50; t++) begin
            @(negedge aclk);
            if (s2_if.tready) begin
                @(posedge aclk);
                #1;
                s2_if.tvalid = 1'b0;
                return;
            end
            @(posedge aclk);
            #1;
        end
        chk("msb_accept_timeout", 32'h0, 32'h1);
        s2_if.tvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        bit bp[6];

        aresetn       = 1'b0;
        s_if.tdata    = '0;
        s_if.tvalid   = 1'b0;
        m_if.tready   = 1'b1;
        s2_if.tdata   = '0;
        s2_if.tvalid  = 1'b0;
        m2_if.tready  = 1'b1;

        // Reset values and the one-edge tready hold-off after release.
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_m_tvalid", {31'h0, m_if.tvalid}, 32'h0);
        chk("rst_m_tdata", {24'h0, m_if.tdata}, 32'h0);
        chk("rst_s_tready", {31'h0, s_if.tready}, 32'h0);
        chk("rst_busy", {31'h0, busy_a}, 32'h0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rel_s_tready_first_edge", {31'h0, s_if.tready}, 32'h0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        chk("rel_s_tready_after", {31'h0, s_if.tready}, 32'h1);
        @(posedge aclk);
        #1;

        // Single word, consecutive beats, input stalled until the last beat.
        send_a(32'h4433_2211, a1);
        s_if.tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            chk("single_s_tready", {31'h0, s_if.tready}, (k == 3) ? 32'h1 : 32'h0);
            chk("single_m_tvalid", {31'h0, m_if.tvalid}, 32'h1);
            chk("single_busy", {31'h0, busy_a}, 32'h1);
            @(posedge aclk);
            #1;
        end
        @(negedge aclk);
        chk("single_idle_tvalid", {31'h0, m_if.tvalid}, 32'h0);
        chk("single_idle_busy", {31'h0, busy_a}, 32'h0);
        @(posedge aclk);
        #1;

        // Back-to-back words with no bubble between them.
        send_a(32'h4433_2211, a1);
        gap_en = 1'b1;
        send_a(32'h8877_6655, a2);
        chk("b2b_accept_cycle", 32'(a2 - a1), 32'd4);
        s_if.tvalid = 1'b0;
        repeat (4) @(negedge aclk);
        @(posedge aclk);
        #1;
        gap_en = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // Backpressure: data must hold while the sink stalls.
        bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        send_a(32'h4433_2211, a1);
        s_if.tvalid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            m_if.tready = bp[k];
            @(negedge aclk);
            if (!bp[k]) begin
                chk("stall_tdata", {24'h0, m_if.tdata}, 32'h22);
                chk("stall_tvalid", {31'h0, m_if.tvalid}, 32'h1);
            end
            @(posedge aclk);
            #1;
        end
        m_if.tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk("bp_queue_drained", exp_a.size(), 32'h0);

        // MSB-first ordering on the second instance.
        send_b(32'hA1B2_C3D4);
        repeat (6) @(posedge aclk);
        #1;
        chk("msb_queue_drained", exp_b.size(), 32'h0);

        // Asynchronous reset in the middle of a word.
        send_a(32'h4433_2211, a1);
        s_if.tvalid = 1'b0;
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
        #2;
        aresetn = 1'b0;
        exp_a.delete();
        #1;
        chk("midrst_tvalid", {31'h0, m_if.tvalid}, 32'h0);
        chk("midrst_tdata", {24'h0, m_if.tdata}, 32'h0);
        chk("midrst_busy", {31'h0, busy_a}, 32'h0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("midrst_rel_tvalid", {31'h0, m_if.tvalid}, 32'h0);
        chk("midrst_rel_s_tready", {31'h0, s_if.tready}, 32'h0);
        @(posedge aclk);
        #1;
        send_a(32'hDDCC_BBAA, a1);
        s_if.tvalid = 1'b0;
        repeat (6) @(posedge aclk);
        #1;
        chk("final_queue_drained", exp_a.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
